// File: rtl/op_program_sequencer.sv
// op_program_sequencer: replays a small stored program of fixed-point stack
// operations into operation_machine over a valid/ready handshake, then waits
// for the machine's done and captures its result.
// Optional build macro OP_SEQ_TIMEOUT_EN adds a watchdog on the WAIT state.
module op_program_sequencer #(
    parameter  int N       = 32,
    parameter  int Q       = 16,
    parameter  int STACK   = 5,
    parameter  int DEPTH   = 16,
    parameter  int TIMEOUT = 1024,
    localparam int IW      = $clog2(STACK) + 2,
    localparam int AW      = $clog2(DEPTH),
    localparam int WW      = 2 + 2 * IW + N
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [WW-1:0] prog_wdata,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    output logic          busy,
    output logic          issue_valid,
    input  logic          issue_ready,
    output logic [1:0]    operand,
    output logic [IW-1:0] index1,
    output logic [IW-1:0] index2,
    output logic [N-1:0]  value,
    input  logic          op_done,
    input  logic [N-1:0]  op_result,
    output logic [N-1:0]  result,
    output logic          result_valid,
    output logic          err
);

    // Q only rides along so this block shares its parameter set with the
    // operation machine; the fraction must still fit inside the datapath.
    if (Q >= N || TIMEOUT < 1) begin : g_bad_params
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW:0]   len_q, len_d;
    logic          busy_q, busy_d;
    logic          ivld_q, ivld_d;
    logic [1:0]    operand_q, operand_d;
    logic [IW-1:0] index1_q, index1_d;
    logic [IW-1:0] index2_q, index2_d;
    logic [N-1:0]  value_q, value_d;
    logic [N-1:0]  result_q, result_d;
    logic          rvld_q, rvld_d;
    logic          err_q, err_d;

    logic [WW-1:0] mem [DEPTH];

    logic len_ok;
    logic last_instr;

    assign len_ok     = (prog_len != '0) && (prog_len <= (AW+1)'(DEPTH));
    assign last_instr = ({1'b0, pc_q} == len_q - (AW+1)'(1));

`ifdef OP_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;
`endif

    // Program store: writable only while idle so a run sees a frozen program.
    always_ff @(posedge clk) begin
        if (prog_we && state_q == S_IDLE) begin
            mem[prog_addr] <= prog_wdata;
        end
    end

    // Next-state and next-output logic for the sequencer FSM.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        len_d     = len_q;
        operand_d = operand_q;
        index1_d  = index1_q;
        index2_d  = index2_q;
        value_d   = value_q;
        result_d  = result_q;
        rvld_d    = 1'b0;
        err_d     = 1'b0;
`ifdef OP_SEQ_TIMEOUT_EN
        tmo_d     = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len_ok) begin
                        len_d   = prog_len;
                        pc_d    = '0;
                        state_d = S_FETCH;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                {operand_d, index1_d, index2_d, value_d} = mem[pc_q];
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (issue_ready) begin
                    if (last_instr) begin
                        state_d = S_WAIT;
`ifdef OP_SEQ_TIMEOUT_EN
                        tmo_d   = '0;
`endif
                    end else begin
                        pc_d    = pc_q + AW'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            S_WAIT: begin
                if (op_done) begin
                    result_d = op_result;
                    state_d  = S_DONE;
                end
`ifdef OP_SEQ_TIMEOUT_EN
                else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
`endif
            end
            S_DONE: begin
                rvld_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        ivld_d = (state_d == S_ISSUE);
    end

    // State and registered outputs; the program store is deliberately not reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            len_q     <= '0;
            busy_q    <= 1'b0;
            ivld_q    <= 1'b0;
            operand_q <= '0;
            index1_q  <= '0;
            index2_q  <= '0;
            value_q   <= '0;
            result_q  <= '0;
            rvld_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef OP_SEQ_TIMEOUT_EN
            tmo_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            len_q     <= len_d;
            busy_q    <= busy_d;
            ivld_q    <= ivld_d;
            operand_q <= operand_d;
            index1_q  <= index1_d;
            index2_q  <= index2_d;
            value_q   <= value_d;
            result_q  <= result_d;
            rvld_q    <= rvld_d;
            err_q     <= err_d;
`ifdef OP_SEQ_TIMEOUT_EN
            tmo_q     <= tmo_d;
`endif
        end
    end

    assign busy         = busy_q;
    assign issue_valid  = ivld_q;
    assign operand      = operand_q;
    assign index1       = index1_q;
    assign index2       = index2_q;
    assign value        = value_q;
    assign result       = result_q;
    assign result_valid = rvld_q;
    assign err          = err_q;

endmodule

// File: tb/tb_op_program_sequencer.sv
// Scoreboard bench for op_program_sequencer: stimulus pushes expected
// instructions, results and error pulses; a negedge monitor pops and compares.
module tb_op_program_sequencer;
    localparam int N       = 32;
    localparam int IW      = 5;
    localparam int AW      = 4;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 8;

    typedef struct packed {
        logic [1:0]    op;
        logic [IW-1:0] i1;
        logic [IW-1:0] i2;
        logic [N-1:0]  v;
    } instr_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [$bits(instr_t)-1:0] prog_wdata = '0;
    logic [AW:0]   prog_len = '0;
    logic          start = 1'b0;
    logic          busy;
    logic          issue_valid;
    logic          issue_ready = 1'b0;
    logic [1:0]    operand;
    logic [IW-1:0] index1;
    logic [IW-1:0] index2;
    logic [N-1:0]  value;
    logic          op_done = 1'b0;
    logic [N-1:0]  op_result = '0;
    logic [N-1:0]  result;
    logic          result_valid;
    logic          err;

    op_program_sequencer #(.N(N), .Q(16), .STACK(5), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .prog_len(prog_len), .start(start), .busy(busy),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .operand(operand),
        .index1(index1), .index2(index2), .value(value), .op_done(op_done),
        .op_result(op_result), .result(result), .result_valid(result_valid), .err(err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int err_exp = 0;
    int err_cyc = -1;
    instr_t exp_q[$];
    logic [N-1:0] res_q[$];
    int hs_q[$];
    instr_t prog[3];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every presented output against the scoreboard.
    logic   hold_prev = 1'b0;
    instr_t prev_f;
    always @(negedge clk) begin
        instr_t cur, e;
        cur = '{op: operand, i1: index1, i2: index2, v: value};
        if (reset) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                vectors++;
                if (!issue_valid || cur != prev_f) begin
                    miscompares++;
                    $display("FAIL stall_hold: got vld=%0b %h, want vld=1 %h", issue_valid, cur, prev_f);
                end
            end
            if (issue_valid && issue_ready) begin
                hs_q.push_back(cyc + 1);
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL issue_unexpected: got %h, want no handshake", cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur != e) begin
                        miscompares++;
                        $display("FAIL issue_fields: got %h, want %h", cur, e);
                    end
                end
            end
            if (result_valid) begin
                vectors++;
                if (res_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL result_unexpected: got %h, want no result_valid", result);
                end else begin
                    logic [N-1:0] r;
                    r = res_q.pop_front();
                    if (result !== r) begin
                        miscompares++;
                        $display("FAIL result: got %h, want %h", result, r);
                    end
                end
            end
            if (err) begin
                vectors++;
                err_cyc = cyc;
                if (err_exp == 0) begin
                    miscompares++;
                    $display("FAIL err_unexpected: got err=1, want 0 at cycle %0d", cyc);
                end else begin
                    err_exp--;
                end
            end
            hold_prev = issue_valid && !issue_ready;
            prev_f    = cur;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 0);
        check({tag, "_ivld"}, 64'(issue_valid), 0);
        check({tag, "_fields"}, 64'({operand, index1, index2}), 0);
        check({tag, "_value"}, 64'(value), 0);
        check({tag, "_result"}, 64'(result), 0);
        check({tag, "_rvld_err"}, 64'({result_valid, err}), 0);
    endtask

    task automatic push_prog();
        for (int k = 0; k < 3; k++) exp_q.push_back(prog[k]);
    endtask

    task automatic do_start(input int len);
        start = 1'b1;
        prog_len = (AW+1)'(len);
        tick();
        start = 1'b0;
    endtask

    // Handshakes n instructions; optionally stalls one and pulses op_done during the stall.
    task automatic drive_issue(input int n, input int stall_on, input int stall_n, input bit done_in_stall);
        for (int k = 0; k < n; k++) begin
            int to;
            to = 0;
            issue_ready = (k != stall_on);
            while (!issue_valid && to < 50) begin
                tick();
                to++;
            end
            if (!issue_valid) begin
                vectors++;
                miscompares++;
                $display("FAIL issue_timeout: got no issue_valid, want instruction %0d", k);
                return;
            end
            if (k == stall_on) begin
                for (int s = 0; s < stall_n; s++) begin
                    op_done   = done_in_stall && (s == 0);
                    op_result = 32'hDEAD_BEEF;
                    tick();
                end
                op_done = 1'b0;
                issue_ready = 1'b1;
            end
            tick();
        end
    endtask

    task automatic finish_op(input logic [N-1:0] r);
        int to;
        res_q.push_back(r);
        op_done = 1'b1;
        op_result = r;
        tick();
        op_done = 1'b0;
        op_result = '0;
        to = 0;
        while (busy && to < 20) begin
            tick();
            to++;
        end
        check("done_busy_low", 64'(busy), 0);
        tick();
        check("result_held", 64'(result), 64'(r));
    endtask

    initial begin
        int s;
        prog[0] = '{op: 2'd0, i1: 5'd0, i2: 5'd1, v: 32'h0};
        prog[1] = '{op: 2'd1, i1: 5'd2, i2: 5'd0, v: 32'h0};
        prog[2] = '{op: 2'd2, i1: 5'd0, i2: 5'd0, v: 32'h0001_0000};

        tick();
        tick();
        check_zero("reset");
        reset = 1'b0;
        tick();
        check_zero("post_reset");

        for (int k = 0; k < 3; k++) begin
            prog_we = 1'b1;
            prog_addr = AW'(k);
            prog_wdata = prog[k];
            tick();
        end
        prog_we = 1'b0;

        // Normal run, ready held high: handshakes on edges start+2/+4/+6.
        push_prog();
        hs_q.delete();
        issue_ready = 1'b1;
        s = cyc + 1;
        do_start(3);
        check("busy_after_start", 64'(busy), 1);
        drive_issue(3, -1, 0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            if (hs_q.size() > k) check("hs_cycle", 64'(hs_q[k]), 64'(s + 2 * (k + 1)));
            else check("hs_count", 64'(hs_q.size()), 3);
        end
        finish_op(32'h0002_8000);

        // Stall instruction 2 for 5 cycles; inject start and a write while in WAIT.
        push_prog();
        do_start(3);
        drive_issue(3, 1, 5, 1'b0);
        start = 1'b1;
        prog_len = 5'd3;
        prog_we = 1'b1;
        prog_addr = '0;
        prog_wdata = '1;
        tick();
        start = 1'b0;
        prog_we = 1'b0;
        check("wait_start_ignored_busy", 64'(busy), 1);
        finish_op(32'h1234_5678);

        // Rerun proves memory unchanged; op_done during ISSUE must not complete.
        push_prog();
        do_start(3);
        drive_issue(3, 0, 3, 1'b1);
        check("busy_after_early_done", 64'(busy), 1);
        finish_op(32'hFFFF_0001);

        // Rejected lengths.
        err_exp++;
        do_start(0);
        check("len0_busy", 64'(busy), 0);
        tick();
        err_exp++;
        do_start(DEPTH + 1);
        check("len17_busy", 64'(busy), 0);
        tick();
        check("err_pulses_seen", 64'(err_exp), 0);

        // Reset while waiting, then a fresh run.
        push_prog();
        do_start(3);
        drive_issue(3, -1, 0, 1'b0);
        check("wait_busy", 64'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        check_zero("midrun_reset");
        tick();
        reset = 1'b0;
        tick();
        push_prog();
        do_start(3);
        drive_issue(3, -1, 0, 1'b0);
        finish_op(32'h0000_0042);

        // Watchdog behaviour with no op_done.
        push_prog();
        hs_q.delete();
        do_start(3);
        drive_issue(3, -1, 0, 1'b0);
`ifdef OP_SEQ_TIMEOUT_EN
        err_exp++;
        err_cyc = -1;
        repeat (TIMEOUT + 3) tick();
        check("timeout_busy", 64'(busy), 0);
        if (hs_q.size() == 3) check("timeout_cycle", 64'(err_cyc), 64'(hs_q[2] + TIMEOUT));
        else check("timeout_hs_count", 64'(hs_q.size()), 3);
`else
        begin
            int low;
            low = 0;
            for (int k = 0; k < 100; k++) begin
                tick();
                if (!busy) low++;
            end
            check("wait_holds_100", 64'(low), 0);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
`endif
        tick();
        check("exp_q_drained", 64'(exp_q.size()), 0);
        check("res_q_drained", 64'(res_q.size()), 0);
        check("err_drained", 64'(err_exp), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish within 500000 time units");
        $fatal(1);
    end
endmodule
